// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the single-bus datapath.
// Drives the per-step control strobes (bus drivers, register loads, ALU op
// select) from the current step and the IR fields.
//
// state  | meaning
// IDLE   | waiting for run; every strobe low
// T0     | PC onto bus, load MAR, increment PC into Z
// T1     | Z onto bus into PC, memory read into MDR; held while !mem_ready
// T2     | MDR onto bus into IR
// T3     | decode: ALU ops drive Rb into Y; HALT and NOPs drive nothing
// T4     | Rc onto bus, ALU op strobe, result into Z
// T5     | Z onto bus, write Ra
// HALT   | halted high, all strobes low; only rst_n leaves
module control_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        mem_ready,
   input  logic [31:0] ir,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        IncPC,
   output logic        Read,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_HALT
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t     state;
   state_t     state_nxt;
   logic [4:0] opcode;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   logic       is_alu;
   logic       ir_unused;

   assign opcode    = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
   assign ir_unused = ^ir[14:0];

   // Step register; reset lands in IDLE immediately, independent of clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-step selection and Moore strobe decode of step plus IR fields.
   always_comb begin
      state_nxt = state;
      PCout     = 1'b0;
      Zlowout   = 1'b0;
      MDRout    = 1'b0;
      MARin     = 1'b0;
      Zin       = 1'b0;
      PCin      = 1'b0;
      MDRin     = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      IncPC     = 1'b0;
      Read      = 1'b0;
      ADD       = 1'b0;
      SUB       = 1'b0;
      AND       = 1'b0;
      OR        = 1'b0;
      Rout      = 16'h0000;
      Rin       = 16'h0000;
      halted    = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_T0;
         end
         S_T0: begin
            PCout     = 1'b1;
            MARin     = 1'b1;
            IncPC     = 1'b1;
            Zin       = 1'b1;
            state_nxt = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_ready) state_nxt = S_T2;
         end
         S_T2: begin
            MDRout    = 1'b1;
            IRin      = 1'b1;
            state_nxt = S_T3;
         end
         S_T3: begin
            if (is_alu) begin
               Rout[rb]  = 1'b1;
               Yin       = 1'b1;
               state_nxt = S_T4;
            end else if (opcode == OP_HALT) begin
               state_nxt = S_HALT;
            end else begin
               state_nxt = run ? S_T0 : S_IDLE;
            end
         end
         S_T4: begin
            Rout[rc]  = 1'b1;
            Zin       = 1'b1;
            ADD       = (opcode == OP_ADD);
            SUB       = (opcode == OP_SUB);
            AND       = (opcode == OP_AND);
            OR        = (opcode == OP_OR);
            state_nxt = S_T5;
         end
         S_T5: begin
            Zlowout   = 1'b1;
            Rin[ra]   = 1'b1;
            state_nxt = run ? S_T0 : S_IDLE;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level reference model compared every
// cycle, plus directed instructions with hand-computed strobe patterns.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        run = 1'b0;
   logic        mem_ready = 1'b1;
   logic [31:0] ir = 32'h0;
   logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
   logic        IncPC, Read, ADD, SUB, AND, OR, halted;
   logic [15:0] Rout, Rin;

   int checks = 0;
   int failures = 0;

   control_unit dut (
      .clk(clk), .rst_n(rst_n), .run(run), .mem_ready(mem_ready), .ir(ir),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
      .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .IncPC(IncPC), .Read(Read), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
      .Rout(Rout), .Rin(Rin), .halted(halted)
   );

   always #5 clk = ~clk;

   // Bit layout: 47 halted, 46 PCout, 45 Zlowout, 44 MDRout, 43 MARin, 42 Zin,
   // 41 PCin, 40 MDRin, 39 IRin, 38 Yin, 37 IncPC, 36 Read, 35 ADD, 34 SUB,
   // 33 AND, 32 OR, 31:16 Rout, 15:0 Rin.
   logic [47:0] dut_v;
   assign dut_v = {halted, PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin,
                   IRin, Yin, IncPC, Read, ADD, SUB, AND, OR, Rout, Rin};

   // Reference model: which step of the instruction we are in.
   localparam int P_IDLE = 0, P_FETCH_PC = 1, P_FETCH_MEM = 2, P_LOAD_IR = 3,
                  P_DECODE = 4, P_EXEC = 5, P_WRITE = 6, P_STOPPED = 7;
   int ph = P_IDLE;

   function automatic bit op_is_alu(input logic [31:0] irv);
      int op;
      op = int'(irv[31:27]);
      return (op == 3) || (op == 4) || (op == 9) || (op == 10);
   endfunction

   function automatic logic [47:0] expect_v(input int p, input logic [31:0] irv);
      logic [47:0] v;
      int op;
      v  = '0;
      op = int'(irv[31:27]);
      case (p)
         P_FETCH_PC:  begin v[46] = 1; v[43] = 1; v[37] = 1; v[42] = 1; end
         P_FETCH_MEM: begin v[45] = 1; v[41] = 1; v[36] = 1; v[40] = 1; end
         P_LOAD_IR:   begin v[44] = 1; v[39] = 1; end
         P_DECODE:    if (op_is_alu(irv)) begin
                         v[16 + int'(irv[22:19])] = 1;
                         v[38] = 1;
                      end
         P_EXEC:      begin
                         v[16 + int'(irv[18:15])] = 1;
                         v[42] = 1;
                         v[35] = (op == 3);
                         v[34] = (op == 4);
                         v[33] = (op == 9);
                         v[32] = (op == 10);
                      end
         P_WRITE:     begin v[45] = 1; v[int'(irv[26:23])] = 1; end
         P_STOPPED:   v[47] = 1;
         default:     v = '0;
      endcase
      return v;
   endfunction

   // Advance the reference model on each rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ph <= P_IDLE;
      else begin
         case (ph)
            P_IDLE:      if (run) ph <= P_FETCH_PC;
            P_FETCH_PC:  ph <= P_FETCH_MEM;
            P_FETCH_MEM: if (mem_ready) ph <= P_LOAD_IR;
            P_LOAD_IR:   ph <= P_DECODE;
            P_DECODE:    if (int'(ir[31:27]) == 27) ph <= P_STOPPED;
                         else if (op_is_alu(ir)) ph <= P_EXEC;
                         else ph <= run ? P_FETCH_PC : P_IDLE;
            P_EXEC:      ph <= P_WRITE;
            P_WRITE:     ph <= run ? P_FETCH_PC : P_IDLE;
            default:     ph <= ph;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      checks++;
      if (dut_v !== expect_v(ph, ir)) begin
         failures++;
         $display("FAIL model_cmp t=%0t phase=%0d got=%h exp=%h", $time, ph,
                  dut_v, expect_v(ph, ir));
      end
   end

   task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   logic [47:0] trace [16];

   // Returns at negedge+1 once back in IDLE.
   task automatic wait_idle(input string name);
      bit ok;
      ok = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (dut_v == 48'h0 && ph == P_IDLE) begin ok = 1; break; end
      end
      if (!ok) chk(name, dut_v, 48'h0);
      #1;
   endtask

   // Called at negedge+1 from IDLE. Measures cycles from T0 to the next T0,
   // stalls T1 for 'stall' cycles, records per-cycle strobes, then drops run
   // so the repeat instruction retires into IDLE.
   task automatic run_instr(input string name, input logic [31:0] irv,
                            input int stall, output int n, output int t1cnt);
      bit ok;
      ir  = irv;
      run = 1'b1;
      mem_ready = (stall == 0);
      @(negedge clk);
      n = 0;
      t1cnt = 0;
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         if (k > 0 && PCout) begin ok = 1; break; end
         if (n < 16) trace[n] = dut_v;
         n++;
         if (Zlowout && PCin) t1cnt++;
         #1 mem_ready = (t1cnt > stall);
         @(negedge clk);
      end
      if (!ok) chk_int({name, "_timeout"}, n, -1);
      #1;
      run = 1'b0;
      mem_ready = 1'b1;
      wait_idle({name, "_idle"});
   endtask

   int n, t1c;
   logic [31:0] ir_alu;
   logic [47:0] exp_and [6];

   initial begin
      exp_and[0] = 48'h4C20_0000_0000;
      exp_and[1] = 48'h2310_0000_0000;
      exp_and[2] = 48'h1080_0000_0000;
      exp_and[3] = 48'h0040_0004_0000;
      exp_and[4] = 48'h0402_0010_0000;
      exp_and[5] = 48'h2000_0000_0020;

      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("por_outputs", dut_v, 48'h0);
      #4 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("por_idle", dut_v, 48'h0);
      end
      #1;

      // AND R5 <- R2 & R4
      run_instr("and", 32'h4A92_0000, 0, n, t1c);
      chk_int("and_len", n, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("and_T%0d", i), trace[i], exp_and[i]);

      // T1 stall of 3 extra cycles
      run_instr("stall", 32'h4A92_0000, 3, n, t1c);
      chk_int("stall_len", n, 9);
      chk_int("stall_t1_cycles", t1c, 4);
      chk("stall_T2", trace[5], 48'h1080_0000_0000);

      // ADD / SUB / OR with Ra = Rb = Rc = 7
      for (int i = 0; i < 3; i++) begin
         logic [4:0] op;
         logic [3:0] opsel;
         op    = (i == 0) ? 5'b00011 : (i == 1) ? 5'b00100 : 5'b01010;
         opsel = (i == 0) ? 4'b1000 : (i == 1) ? 4'b0100 : 4'b0001;
         ir_alu = {op, 4'd7, 4'd7, 4'd7, 15'd0};
         run_instr("op", ir_alu, 0, n, t1c);
         chk_int($sformatf("op%0d_len", i), n, 6);
         chk($sformatf("op%0d_T3_rout", i), {32'h0, trace[3][31:16]}, 48'h0080);
         chk($sformatf("op%0d_T4_rout", i), {32'h0, trace[4][31:16]}, 48'h0080);
         chk($sformatf("op%0d_T4_opsel", i), {44'h0, trace[4][35:32]}, {44'h0, opsel});
         chk($sformatf("op%0d_T5_rin", i), {32'h0, trace[5][15:0]}, 48'h0080);
      end

      // NOP: opcode 0, register fields nonzero
      run_instr("nop", 32'h07FF_8000, 0, n, t1c);
      chk_int("nop_len", n, 4);
      chk("nop_T3", trace[3], 48'h0);

      // Reset asserted asynchronously in the middle of T4
      ir  = 32'h4A92_0000;
      run = 1'b1;
      for (int i = 0; i < 5; i++) @(negedge clk);
      chk("rst_pre_T4", dut_v, 48'h0402_0010_0000);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_zero", dut_v, 48'h0);
      run = 1'b0;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("rst_idle_%0d", i), dut_v, 48'h0);
      end
      #1;

      // run dropped in T4: SUB R3 <- R1 - R2 still writes back
      ir  = {5'b00100, 4'd3, 4'd1, 4'd2, 15'd0};
      run = 1'b1;
      for (int i = 0; i < 5; i++) @(negedge clk);
      #1 run = 1'b0;
      @(negedge clk);
      chk("drop_T5", dut_v, 48'h2000_0000_0008);
      @(negedge clk);
      chk("drop_idle0", dut_v, 48'h0);
      @(negedge clk);
      chk("drop_idle1", dut_v, 48'h0);
      #1;

      // HALT: sticky until reset, ignores run
      ir  = {5'b11011, 27'h0};
      run = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("halt_T3", dut_v, 48'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("halt_hold_%0d", i), dut_v, 48'h8000_0000_0000);
         #1 run = (i < 4);
      end
      #2 rst_n = 1'b0;
      #1 chk("halt_rst_zero", dut_v, 48'h0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("halt_after_rst", dut_v, 48'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "bench watchdog expired");
   end

endmodule
